gcd_arbiter: RTL and testbench
==============================

// Module: gcd_arbiter
// PURPOSE
//  Shares one subtractive GCD engine (start/valid/out, 16-bit) among NREQ requesters.
//  Round-robin arbitration, operand capture, one-cycle engine start pulse, wait for valid,
//  result routed back to the granted requester. Sits between client blocks and the engine;
//  engine clk/rst are tied to this block's clk/rst.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  W     16  operand/result width; must match engine width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  req        in   NREQ    per-requester request level; hold with operands until gnt
//  a_req      in   NREQ*W  operand A, requester i at [i*W +: W]
//  b_req      in   NREQ*W  operand B, same packing
//  gnt        out  NREQ    one-hot, 1-cycle pulse: operands of that requester captured
//  rsp_valid  out  NREQ    one-hot, 1-cycle pulse: rsp_data belongs to that requester
//  rsp_data   out  W       GCD result, meaningful only while any rsp_valid bit is 1
//  busy       out  1       1 whenever state != IDLE
//  eng_start  out  1       1-cycle start pulse to engine
//  eng_a      out  W       operand A to engine (stable from ISSUE until RESP)
//  eng_b      out  W       operand B to engine
//  eng_valid  in   1       engine result strobe
//  eng_out    in   W       engine result
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, busy=0,
//    eng_start=0, eng_a=0, eng_b=0, rr_ptr=0, owner=0.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    IDLE : any req bit set -> pick winner, latch its operands to eng_a/eng_b, owner=winner,
//           next cycle ISSUE with gnt[winner]=1 and eng_start=1 (same cycle).
//    ISSUE: exactly one cycle; gnt/eng_start drop after it; -> WAIT.
//    WAIT : hold until eng_valid=1; latch eng_out to rsp_data; -> RESP.
//    RESP : rsp_valid[owner]=1 for one cycle; -> IDLE.
//  - Round-robin: search starts at rr_ptr, wraps modulo NREQ; on grant rr_ptr=winner+1
//    (NREQ-1 wraps to 0). Requester with req still high after its grant is a new request,
//    lowest precedence next round.
//  - req dropped before gnt: withdrawn, no grant, no state change.
//  - Only one job in flight; req sampled only in IDLE; other requesters wait.
//  - eng_valid outside WAIT ignored (no state change, no rsp).
//  - eng_start never asserted outside ISSUE; never held >1 cycle (engine restarts on start).
//  - Latency (engine, equal nonzero operands = 3 cycles start->valid): req in cycle 0 ->
//    gnt/eng_start cycle 1 -> eng_valid cycle 4 -> rsp_valid cycle 5 -> IDLE cycle 6,
//    next gnt earliest cycle 7.
//  - rst mid-job: everything returns to reset values next edge; in-flight job lost,
//    no rsp_valid; engine is reset by the same rst.
// CONFIGURATION
//  GCD_ARB_ZERO_BYPASS_EN defined: in IDLE, if the winner's a or b is 0, gnt pulses but
//    eng_start stays 0; next state RESP directly, rsp_data=0 (engine zero convention);
//    rsp_valid 2 cycles after req. Engine untouched.
//  Not defined: zero operands go through the engine like any job (result 0 from engine).
// TESTING
//  1 single: req[0], a=48,b=18 -> gnt[0] cycle 1, eng_start 1 cycle, rsp_valid[0] with 6.
//  2 equal: req[2], a=b=7 -> gnt cycle 1, rsp_valid[2]=1 rsp_data=7 exactly cycle 5.
//  3 round-robin: req=4'b1111 held, a=12,b=8 all -> grant order 0,1,2,3,0; each rsp=4.
//  4 zero: req[1], a=0,b=9 -> rsp_data=0; with GCD_ARB_ZERO_BYPASS_EN eng_start never 1
//    and rsp_valid[1] at cycle 2; without it eng_start pulses once.
//  5 reset mid-job: req[3] a=65535,b=1, rst in WAIT -> busy=0, no rsp_valid, new req[0]
//    a=9,b=6 then returns 3.
//  6 spurious eng_valid=1 in IDLE, eng_out=5 -> no rsp_valid, rsp_data unchanged.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one start/valid GCD engine among NREQ requesters.
// Optional feature: define GCD_ARB_ZERO_BYPASS_EN to answer zero-operand jobs without the engine.
module gcd_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_req,
  input  logic [NREQ*W-1:0] b_req,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  output logic              eng_start,
  output logic [W-1:0]      eng_a,
  output logic [W-1:0]      eng_b,
  input  logic              eng_valid,
  input  logic [W-1:0]      eng_out
);

  localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0]      rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic              eng_start_q, eng_start_d;
  logic [W-1:0]      eng_a_q, eng_a_d;
  logic [W-1:0]      eng_b_q, eng_b_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic              bypass_q, bypass_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW-1:0]     next_ptr;
  logic [W-1:0]      win_a, win_b;
  logic              zero_op;

  // Circular search from rr_ptr; first requesting index wins.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NR) idx = idx - NR;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    int unsigned wi;
    wi       = 32'(win);
    win_a    = a_req[wi*W +: W];
    win_b    = b_req[wi*W +: W];
    next_ptr = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
    zero_op  = (win_a == '0) || (win_b == '0);
`else
    zero_op  = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    eng_start_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    bypass_d    = bypass_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d    = win;
          rr_ptr_d   = next_ptr;
          gnt_d[win] = 1'b1;
          bypass_d   = zero_op;
          state_d    = ISSUE;
          if (!zero_op) begin
            eng_a_d     = win_a;
            eng_b_d     = win_b;
            eng_start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Bypassed jobs skip WAIT so the response lands two cycles after the request.
        if (bypass_q) begin
          rsp_data_d           = '0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (eng_valid) begin
          rsp_data_d           = eng_out;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      bypass_q    <= bypass_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: behavioural engine, directed cases, randomized round-robin jobs.
module tb_gcd_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_req = '0;
  logic [NREQ*W-1:0] b_req = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      rsp_data, eng_a, eng_b, eng_out;
  logic              busy, eng_start, eng_valid;

  gcd_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_req(a_req), .b_req(b_req),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_valid(eng_valid), .eng_out(eng_out)
  );

  always #5 clk = ~clk;

`ifdef GCD_ARB_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int ptr   = 0;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x, y, t;
    if (a == 0 || b == 0) return '0;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return W'(x);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Behavioural engine: result after eng_lat cycles from the start strobe.
  int            eng_lat = 3;
  int            ecnt = 0;
  bit            ebusy = 0;
  logic [W-1:0]  eres = '0;
  logic          ev_m = 1'b0;
  logic [W-1:0]  eo_m = '0;
  logic          spur_v = 1'b0;
  logic [W-1:0]  spur_out = '0;

  always @(posedge clk) begin
    if (rst) begin
      ebusy <= 0; ev_m <= 1'b0; ecnt <= 0;
    end else begin
      ev_m <= 1'b0;
      if (eng_start) begin
        ebusy <= 1; ecnt <= eng_lat - 1; eres <= ref_gcd(eng_a, eng_b);
      end else if (ebusy) begin
        if (ecnt == 1) begin ev_m <= 1'b1; eo_m <= eres; ebusy <= 0; end
        else ecnt <= ecnt - 1;
      end
    end
  end

  assign eng_valid = ev_m | spur_v;
  assign eng_out   = spur_v ? spur_out : eo_m;

  int start_cnt = 0;
  int rsp_cnt   = 0;
  always @(negedge clk) begin
    if (eng_start) start_cnt <= start_cnt + 1;
    if (rsp_valid != '0) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; ptr = 0;
  endtask

  task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    a_req[r*W +: W] = a;
    b_req[r*W +: W] = b;
  endtask

  task automatic single(input string tag, input int r, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat);
    int n, s0, exp_st;
    bit zero;
    zero   = (a == 0) || (b == 0);
    exp_st = (BYPASS && zero) ? 0 : 1;
    eng_lat = lat;
    set_ops(r, a, b);
    s0 = start_cnt;
    req = NREQ'(1 << r);
    n = 0;
    do begin tick(); n++; end while (gnt == '0 && n < 30);
    chk({tag, "_gnt"}, gnt, 32'(1 << r));
    chk({tag, "_gnt_lat"}, n, 1);
    chk({tag, "_start_at_gnt"}, eng_start, exp_st);
    req = '0;
    ptr = (r + 1) % NREQ;
    do begin tick(); n++; end while (rsp_valid == '0 && n < 100);
    chk({tag, "_rsp_owner"}, rsp_valid, 32'(1 << r));
    chk({tag, "_rsp_data"}, rsp_data, ref_gcd(a, b));
    chk({tag, "_rsp_lat"}, n, (BYPASS && zero) ? 2 : 2 + lat);
    chk({tag, "_starts"}, start_cnt - s0, exp_st);
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [NREQ-1:0] mask;
    logic [W-1:0]    ra [NREQ];
    logic [W-1:0]    rb [NREQ];
    int n, e, s0, r0;
    logic [W-1:0] d0;

    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_eng_b", eng_b, 0);

    single("single", 0, 16'd48, 16'd18, 3);

    // Spurious engine strobe while idle must be ignored.
    d0 = rsp_data; r0 = rsp_cnt;
    spur_out = 16'd5; spur_v = 1'b1; tick(); spur_v = 1'b0;
    repeat (3) tick();
    chk("spur_no_rsp", rsp_cnt - r0, 0);
    chk("spur_data_kept", rsp_data, d0);
    chk("spur_idle", busy, 0);

    single("equal", 2, 16'd7, 16'd7, 3);
    single("zero", 1, 16'd0, 16'd9, 3);

    // Round-robin with all requesters held.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'd12, 16'd8);
    req = '1;
    eng_lat = 4;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin tick(); n++; end while (gnt == '0 && n < 40);
      e = rr_pick(req, ptr);
      chk("rr_gnt", gnt, 32'(1 << e));
      ptr = (e + 1) % NREQ;
      do begin tick(); n++; end while (rsp_valid == '0 && n < 100);
      chk("rr_owner", rsp_valid, 32'(1 << e));
      chk("rr_data", rsp_data, 4);
      if (k == 4) req = '0;
    end
    repeat (3) tick();
    chk("rr_idle", busy, 0);

    // Reset while the engine is working.
    eng_lat = 20;
    set_ops(3, 16'hFFFF, 16'd1);
    req = 4'b1000;
    n = 0;
    do begin tick(); n++; end while (gnt == '0 && n < 30);
    chk("midrst_gnt", gnt, 4'b1000);
    req = '0;
    tick(); tick();
    chk("midrst_busy_before", busy, 1);
    r0 = rsp_cnt;
    rst = 1'b1; tick(); rst = 1'b0; ptr = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_eng_a", eng_a, 0);
    chk("midrst_eng_b", eng_b, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    repeat (25) tick();
    chk("midrst_no_rsp", rsp_cnt - r0, 0);
    single("after_rst", 0, 16'd9, 16'd6, 3);

    // Randomized rounds; pending requesters may withdraw while a job is in flight.
    for (int round = 0; round < 25; round++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        int g;
        g = $urandom_range(1, 20);
        ra[i] = ($urandom_range(0, 7) == 0) ? 16'd0 : W'(g * $urandom_range(1, 60));
        rb[i] = ($urandom_range(0, 7) == 0) ? 16'd0 : W'(g * $urandom_range(1, 60));
        set_ops(i, ra[i], rb[i]);
      end
      req = mask;
      while (mask != '0) begin
        n = 0;
        do begin tick(); n++; end while (gnt == '0 && n < 40);
        e = rr_pick(mask, ptr);
        chk("rand_gnt", gnt, 32'(1 << e));
        s0 = start_cnt;
        eng_lat = $urandom_range(2, 8);
        ptr = (e + 1) % NREQ;
        mask[e] = 1'b0;
        if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, NREQ - 1)] = 1'b0;
        req = mask;
        do begin tick(); n++; end while (rsp_valid == '0 && n < 100);
        chk("rand_owner", rsp_valid, 32'(1 << e));
        chk("rand_data", rsp_data, ref_gcd(ra[e], rb[e]));
        chk("rand_starts", start_cnt - s0,
            (BYPASS && (ra[e] == 0 || rb[e] == 0)) ? 0 : 1);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
